booth_mul_seq: RTL and testbench

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/booth_mul_seq.sv | 124 ++++++++++++
 tb/tb_booth_mul_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift iteration per clock,
// N iterations per signed N x N product, with a start/busy/done handshake.
module booth_mul_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   br,
    input  logic [N-1:0]   qr,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] ac
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [N:0]   a;
    logic        [N-1:0] q;
    logic                q_1;
    logic signed [N-1:0] m;
    logic        [CW-1:0] count;
    logic                armed;

    logic                accept;
    logic                last;
    logic signed [N:0]   a_sum;

    // A is one bit wider than M so that subtracting M = -2^(N-1) cannot overflow.
    function automatic logic signed [N:0] booth_step(
        input logic signed [N:0]   acc,
        input logic signed [N-1:0] mc,
        input logic        [1:0]   pair
    );
        logic signed [N:0] mx;
        mx = {mc[N-1], mc};
        case (pair)
            2'b10:   booth_step = acc - mx;
            2'b01:   booth_step = acc + mx;
            default: booth_step = acc;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start && armed) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        a_sum = booth_step(a, m, {q[0], q_1});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // armed stays low through the edge on which reset is released, so a start
    // coinciding with that edge is not taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            count <= '0;
            ac    <= '0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                m     <= br;
                q     <= qr;
                a     <= '0;
                q_1   <= 1'b0;
                count <= CW'(N);
            end else if (state == RUN) begin
                a     <= {a_sum[N], a_sum[N:1]};
                q     <= {a_sum[0], q[N-1:1]};
                q_1   <= q[0];
                count <= count - 1'b1;
                // Low 2N bits of the shifted {A,Q}: shifted A[N-1:0] is a_sum[N:1].
                if (last) begin
                    ac <= {a_sum, q[N-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed handshake/boundary scenarios
// plus randomized operands against a plain signed-product reference.
module tb_booth_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic        start8;
    logic [7:0]  br8, qr8;
    logic        busy8, done8;
    logic [15:0] ac8;

    logic        start4;
    logic [3:0]  br4, qr4;
    logic        busy4, done4;
    logic [7:0]  ac4;

    logic        start8r [4];
    logic [7:0]  br8r    [4];
    logic [7:0]  qr8r    [4];
    logic        busy8r  [4];
    logic        done8r  [4];
    logic [15:0] ac8r    [4];

    logic        start13r[4];
    logic [12:0] br13r   [4];
    logic [12:0] qr13r   [4];
    logic        busy13r [4];
    logic        done13r [4];
    logic [25:0] ac13r   [4];

    int checks = 0;
    int failures = 0;
    int workers_done = 0;

    booth_mul_seq #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .br(br8), .qr(qr8),
        .busy(busy8), .done(done8), .ac(ac8)
    );

    booth_mul_seq #(.N(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .br(br4), .qr(qr4),
        .busy(busy4), .done(done4), .ac(ac4)
    );

    for (genvar g = 0; g < 4; g++) begin : g_r8
        booth_mul_seq #(.N(8)) u (
            .clk(clk), .rst(rst), .start(start8r[g]), .br(br8r[g]), .qr(qr8r[g]),
            .busy(busy8r[g]), .done(done8r[g]), .ac(ac8r[g])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_r13
        booth_mul_seq #(.N(13)) u (
            .clk(clk), .rst(rst), .start(start13r[g]), .br(br13r[g]), .qr(qr13r[g]),
            .busy(busy13r[g]), .done(done13r[g]), .ac(ac13r[g])
        );
    end

    // Start one N=8 operation and watch 12 cycles after the accepting edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output logic [15:0] p,
                        output int busy_cyc, output int done_cnt, output int lat);
        @(negedge clk);
        br8 = a; qr8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; br8 = 8'($urandom); qr8 = 8'($urandom);
        busy_cyc = 0; done_cnt = 0; lat = -1; p = 'x;
        for (int i = 0; i < 12; i++) begin
            if (busy8) busy_cyc++;
            if (done8) begin
                done_cnt++;
                if (lat < 0) begin lat = i; p = ac8; end
            end
            @(negedge clk);
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, output logic [7:0] p,
                        output int busy_cyc, output int done_cnt, output int lat);
        @(negedge clk);
        br4 = a; qr4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; br4 = 4'($urandom); qr4 = 4'($urandom);
        busy_cyc = 0; done_cnt = 0; lat = -1; p = 'x;
        for (int i = 0; i < 8; i++) begin
            if (busy4) busy_cyc++;
            if (done4) begin
                done_cnt++;
                if (lat < 0) begin lat = i; p = ac4; end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || ac8 !== 16'h0) begin
            failures++;
            $display("FAIL reset_n8 busy=%b done=%b ac=%h required 0/0/0000", busy8, done8, ac8);
        end
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || ac4 !== 8'h0) begin
            failures++;
            $display("FAIL reset_n4 busy=%b done=%b ac=%h required 0/0/00", busy4, done4, ac4);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || ac8 !== 16'h0) begin
                failures++;
                $display("FAIL idle_hold cycle=%0d busy=%b done=%b ac=%h required 0/0/0000",
                         i, busy8, done8, ac8);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int bc, dc, lat;
        run8(8'sd7, -8'sd3, p, bc, dc, lat);
        checks++;
        if (p !== 16'hFFEB) begin failures++; $display("FAIL basic_ac got=%h required=%h", p, 16'hFFEB); end
        checks++;
        if (bc != 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d required=8", bc); end
        checks++;
        if (dc != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d required=1", dc); end
        checks++;
        if (lat != 8) begin failures++; $display("FAIL basic_latency got=%0d required=8", lat); end
        checks++;
        if (ac8 !== 16'hFFEB) begin failures++; $display("FAIL basic_ac_held got=%h required=%h", ac8, 16'hFFEB); end
    endtask

    task automatic test_extremes8();
        logic [15:0] p;
        int bc, dc, lat;
        run8(8'h80, 8'h80, p, bc, dc, lat);
        checks++;
        if (p !== 16'h4000) begin failures++; $display("FAIL min_x_min got=%h required=%h", p, 16'h4000); end
        run8(8'h80, 8'sd127, p, bc, dc, lat);
        checks++;
        if (p !== 16'hC080) begin failures++; $display("FAIL min_x_max got=%h required=%h", p, 16'hC080); end
        checks++;
        if (dc != 1 || lat != 8) begin
            failures++;
            $display("FAIL min_x_max_timing done_pulses=%0d latency=%0d required 1/8", dc, lat);
        end
    endtask

    task automatic test_n4();
        logic [7:0] p;
        int bc, dc, lat;
        run4(4'b1000, 4'b1000, p, bc, dc, lat);
        checks++;
        if (p !== 8'h40) begin failures++; $display("FAIL n4_min_x_min got=%h required=%h", p, 8'h40); end
        checks++;
        if (bc != 4 || lat != 4 || dc != 1) begin
            failures++;
            $display("FAIL n4_timing busy=%0d latency=%0d done_pulses=%0d required 4/4/1", bc, lat, dc);
        end
        run4(4'b1000, 4'sd7, p, bc, dc, lat);
        checks++;
        if (p !== 8'hC8) begin failures++; $display("FAIL n4_min_x_max got=%h required=%h", p, 8'hC8); end
    endtask

    task automatic test_handshake();
        int lat;
        @(negedge clk);
        br8 = 8'sd5; qr8 = 8'sd6; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            if (done8) begin lat = i; break; end
            start8 = (i == 2);
            if (i == 2) begin br8 = 8'sd1; qr8 = 8'sd1; end
            @(negedge clk);
        end
        checks++;
        if (ac8 !== 16'd30 || lat != 8) begin
            failures++;
            $display("FAIL ignore_start_in_run ac=%h latency=%0d required 001e/8", ac8, lat);
        end
        br8 = -8'sd3; qr8 = 8'sd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_start busy=%b done=%b required 1/0", busy8, done8);
        end
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            if (done8) begin lat = i; break; end
            @(negedge clk);
        end
        checks++;
        if (ac8 !== 16'hFFE5 || lat != 8) begin
            failures++;
            $display("FAIL back_to_back_result ac=%h latency=%0d required ffe5/8", ac8, lat);
        end
    endtask

    task automatic test_abort();
        logic [15:0] p;
        int bc, dc, lat, late_done;
        @(negedge clk);
        br8 = 8'sd100; qr8 = -8'sd50; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || ac8 !== 16'h0) begin
            failures++;
            $display("FAIL abort_immediate busy=%b done=%b ac=%h required 0/0/0000", busy8, done8, ac8);
        end
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) late_done++;
            @(negedge clk);
        end
        checks++;
        if (late_done != 0 || ac8 !== 16'h0) begin
            failures++;
            $display("FAIL abort_no_done activity_cycles=%0d ac=%h required 0/0000", late_done, ac8);
        end
        run8(8'sd100, -8'sd50, p, bc, dc, lat);
        checks++;
        if (p !== 16'hEC78 || lat != 8) begin
            failures++;
            $display("FAIL abort_rerun ac=%h latency=%0d required ec78/8", p, lat);
        end
    endtask

    // Back-to-back random stream on one N=8 instance; start stays high throughout.
    task automatic rand8(input int k, input int nops);
        logic signed [7:0] a, b;
        logic [15:0] exp_p;
        int w;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom);
        br8r[k] = a; qr8r[k] = b; start8r[k] = 1'b1;
        for (int n = 0; n < nops; n++) begin
            exp_p = 16'(longint'(a) * longint'(b));
            @(negedge clk);
            br8r[k] = 8'($urandom); qr8r[k] = 8'($urandom);
            w = 1;
            while (!done8r[k] && w < 40) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w != 9 || ac8r[k] !== exp_p) begin
                failures++;
                $display("FAIL rand_n8[%0d] br=%0d qr=%0d ac=%h required=%h cycles=%0d required=9",
                         k, a, b, ac8r[k], exp_p, w);
            end
            if (n == nops - 1 || w >= 40) begin
                start8r[k] = 1'b0;
                break;
            end
            a = 8'($urandom); b = 8'($urandom);
            br8r[k] = a; qr8r[k] = b;
        end
        workers_done++;
    endtask

    task automatic rand13(input int k, input int nops);
        logic signed [12:0] a, b;
        logic [25:0] exp_p;
        int w;
        @(negedge clk);
        a = 13'($urandom); b = 13'($urandom);
        br13r[k] = a; qr13r[k] = b; start13r[k] = 1'b1;
        for (int n = 0; n < nops; n++) begin
            exp_p = 26'(longint'(a) * longint'(b));
            @(negedge clk);
            br13r[k] = 13'($urandom); qr13r[k] = 13'($urandom);
            w = 1;
            while (!done13r[k] && w < 40) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w != 14 || ac13r[k] !== exp_p) begin
                failures++;
                $display("FAIL rand_n13[%0d] br=%0d qr=%0d ac=%h required=%h cycles=%0d required=14",
                         k, a, b, ac13r[k], exp_p, w);
            end
            if (n == nops - 1 || w >= 40) begin
                start13r[k] = 1'b0;
                break;
            end
            a = 13'($urandom); b = 13'($urandom);
            br13r[k] = a; qr13r[k] = b;
        end
        workers_done++;
    endtask

    task automatic test_random();
        workers_done = 0;
        for (int k = 0; k < 4; k++) begin
            fork
                automatic int kk = k;
                rand8(kk, 2500);
                rand13(kk, 2500);
            join_none
        end
        wait (workers_done == 8);
    endtask

    initial begin
        start8 = 1'b0; br8 = '0; qr8 = '0;
        start4 = 1'b0; br4 = '0; qr4 = '0;
        for (int k = 0; k < 4; k++) begin
            start8r[k] = 1'b0;  br8r[k] = '0;  qr8r[k] = '0;
            start13r[k] = 1'b0; br13r[k] = '0; qr13r[k] = '0;
        end
        test_reset();
        test_basic();
        test_extremes8();
        test_n4();
        test_handshake();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
